// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - two-digit multiplexed seven-segment scan decoder
//
// Samples a scanned, active-low seven-segment bus and debounces each digit
// phase. Once both digits have been accepted, the block presents them as one
// frame under a valid/ready handshake.
//
// Ports:
//   clkOut   scan-rate clock, rising edge
//   reset    asynchronous active-low reset
//   seg      segment bus {g,f,e,d,c,b,a}, active-low
//   Enable   digit select: 2'b10 left, 2'b01 right, anything else idle
//   Ldigit   presented left value (hex 0..F)
//   Rdigit   presented right value (0..7)
//   valid    frame held on Ldigit/Rdigit
//   ready    consumer takes the frame
//   err      sticky: invalid pattern or right value above 7
//   overrun  sticky: a complete frame was dropped while valid was pending
//   clr      synchronous clear of err, overrun (and errcnt)
//   errcnt   saturating error-event count, present only with SCAN_ERRCNT_EN
//
// Optional feature macro: SCAN_ERRCNT_EN
module sevenseg_scan_decoder #(
    parameter int STABLE_CNT = 3
) (
    input  logic       clkOut,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [1:0] Enable,
    output logic [3:0] Ldigit,
    output logic [2:0] Rdigit,
    output logic       valid,
    input  logic       ready,
    output logic       err,
    output logic       overrun,
`ifdef SCAN_ERRCNT_EN
    output logic [7:0] errcnt,
`endif
    input  logic       clr
);

    typedef enum logic {COLLECT, PRESENT} state_t;

    localparam logic [3:0] STABLE      = 4'(STABLE_CNT);
    localparam logic [8:0] IDLE_SAMPLE = 9'h000;

    state_t     state;
    logic [8:0] prev;
    logic [3:0] cnt;
    logic       lgot;
    logic       rgot;
    logic [3:0] lshadow;
    logic [2:0] rshadow;

    logic [8:0] sample;
    logic [6:0] pattern;
    logic       active;
    logic       same;
    logic [3:0] cnt_next;
    logic       accept;
    logic       code_ok;
    logic [3:0] code_val;
    logic       left_load;
    logic       right_load;
    logic       err_event;
    logic       frame_done;
    logic       drop;

    assign sample  = {Enable, seg};
    assign pattern = ~seg;
    assign active  = (Enable == 2'b10) || (Enable == 2'b01);
    assign same    = (sample == prev);

    always_comb begin
        code_ok  = 1'b1;
        code_val = 4'h0;
        case (pattern)
            7'h3F: code_val = 4'h0;
            7'h06: code_val = 4'h1;
            7'h5B: code_val = 4'h2;
            7'h4F: code_val = 4'h3;
            7'h66: code_val = 4'h4;
            7'h6D: code_val = 4'h5;
            7'h7D: code_val = 4'h6;
            7'h07: code_val = 4'h7;
            7'h7F: code_val = 4'h8;
            7'h6F: code_val = 4'h9;
            7'h77: code_val = 4'hA;
            7'h7C: code_val = 4'hB;
            7'h39: code_val = 4'hC;
            7'h5E: code_val = 4'hD;
            7'h79: code_val = 4'hE;
            7'h71: code_val = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    always_comb begin
        cnt_next = 4'd0;
        if (active) begin
            if (!same)
                cnt_next = 4'd1;
            else if (cnt >= STABLE)
                cnt_next = STABLE;
            else
                cnt_next = cnt + 4'd1;
        end
    end

    // A run is accepted only on the edge where it first reaches STABLE; a
    // saturated run of the same sample keeps cnt at STABLE without re-firing.
    assign accept     = active && (cnt_next == STABLE) && !(same && (cnt == STABLE));
    assign left_load  = accept && code_ok && (Enable == 2'b10);
    assign right_load = accept && code_ok && !code_val[3] && (Enable == 2'b01);
    assign err_event  = accept && !left_load && !right_load;
    assign frame_done = lgot && rgot;
    assign drop       = (state == PRESENT) && frame_done && !ready;

    always_ff @(posedge clkOut or negedge reset) begin
        if (!reset) begin
            state   <= COLLECT;
            prev    <= IDLE_SAMPLE;
            cnt     <= 4'd0;
            lgot    <= 1'b0;
            rgot    <= 1'b0;
            lshadow <= 4'd0;
            rshadow <= 3'd0;
            Ldigit  <= 4'd0;
            Rdigit  <= 3'd0;
            valid   <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
`ifdef SCAN_ERRCNT_EN
            errcnt  <= 8'd0;
`endif
        end else begin
            prev <= active ? sample : IDLE_SAMPLE;
            cnt  <= cnt_next;

            // A digit accepted on the completion edge belongs to the next
            // frame, so a fresh load takes priority over the clear.
            lgot <= left_load  || (lgot && !frame_done);
            rgot <= right_load || (rgot && !frame_done);
            if (left_load)
                lshadow <= code_val;
            if (right_load)
                rshadow <= code_val[2:0];

            case (state)
                COLLECT: begin
                    if (frame_done) begin
                        Ldigit <= lshadow;
                        Rdigit <= rshadow;
                        valid  <= 1'b1;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (frame_done && ready) begin
                        Ldigit <= lshadow;
                        Rdigit <= rshadow;
                    end else if (!frame_done && ready) begin
                        valid <= 1'b0;
                        state <= COLLECT;
                    end
                end
            endcase

            if (drop)
                overrun <= 1'b1;
            else if (clr)
                overrun <= 1'b0;

            if (err_event)
                err <= 1'b1;
            else if (clr)
                err <= 1'b0;

`ifdef SCAN_ERRCNT_EN
            if (clr)
                errcnt <= err_event ? 8'd1 : 8'd0;
            else if (err_event && (errcnt != 8'hFF))
                errcnt <= errcnt + 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - self-checking bench for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

    localparam int STABLE = 3;

    logic       clkOut = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic [1:0] Enable;
    logic [3:0] Ldigit;
    logic [2:0] Rdigit;
    logic       valid;
    logic       ready;
    logic       err;
    logic       overrun;
    logic       clr;
`ifdef SCAN_ERRCNT_EN
    logic [7:0] errcnt;
`endif

    int nvec = 0;
    int nerr = 0;
    bit checking = 1'b0;

    always #5 clkOut = ~clkOut;

    sevenseg_scan_decoder #(.STABLE_CNT(STABLE)) dut (
        .clkOut  (clkOut),
        .reset   (reset),
        .seg     (seg),
        .Enable  (Enable),
        .Ldigit  (Ldigit),
        .Rdigit  (Rdigit),
        .valid   (valid),
        .ready   (ready),
        .err     (err),
        .overrun (overrun),
`ifdef SCAN_ERRCNT_EN
        .errcnt  (errcnt),
`endif
        .clr     (clr)
    );

    // Behavioural model: run lengths as plain integers, digit lookup by table search.
    logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         run;
    logic [8:0] last;
    bit         lgot, rgot, both;
    int         lsh, rsh, v;
    int         m_l, m_r, m_cnt;
    bit         m_valid, m_err, m_ovr;

    function automatic int lookup(input logic [6:0] s);
        logic [6:0] p;
        p = ~s;
        for (int i = 0; i < 16; i++)
            if (codes[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clkOut or negedge reset) begin
        if (!reset) begin
            run = 0; last = '0; lgot = 0; rgot = 0; lsh = 0; rsh = 0;
            m_l = 0; m_r = 0; m_valid = 0; m_err = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            both = lgot && rgot;
            if (clr) begin
                m_err = 0;
                m_ovr = 0;
                m_cnt = 0;
            end
            if (both) begin
                if (!m_valid || ready) begin
                    m_l = lsh;
                    m_r = rsh;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
                lgot = 0;
                rgot = 0;
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
            if (Enable == 2'b10 || Enable == 2'b01) begin
                if ({Enable, seg} == last) run++;
                else run = 1;
                last = {Enable, seg};
                if (run == STABLE) begin
                    v = lookup(seg);
                    if (v >= 0 && Enable == 2'b10) begin
                        lsh = v; lgot = 1;
                    end else if (v >= 0 && v <= 7 && Enable == 2'b01) begin
                        rsh = v; rgot = 1;
                    end else begin
                        m_err = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end else begin
                run = 0;
                last = '0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clkOut) begin
        if (checking) begin
            chk("model Ldigit", int'(Ldigit), m_l);
            chk("model Rdigit", int'(Rdigit), m_r);
            chk("model valid", int'(valid), int'(m_valid));
            chk("model err", int'(err), int'(m_err));
            chk("model overrun", int'(overrun), int'(m_ovr));
`ifdef SCAN_ERRCNT_EN
            chk("model errcnt", int'(errcnt), m_cnt);
`endif
        end
    end

    // Called at a negedge; applies one input set per cycle, returns at a negedge.
    task automatic drive(input logic [1:0] e, input logic [6:0] s, input logic r,
                         input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            Enable = e; seg = s; ready = r; clr = c;
            @(negedge clkOut);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " Ldigit"}, int'(Ldigit), 0);
        chk({tag, " Rdigit"}, int'(Rdigit), 0);
        chk({tag, " valid"}, int'(valid), 0);
        chk({tag, " err"}, int'(err), 0);
        chk({tag, " overrun"}, int'(overrun), 0);
    endtask

    initial begin
        reset = 1'b0; Enable = 2'b00; seg = 7'h7F; ready = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clkOut);
        check_all_zero("reset");
        reset = 1'b1;
        checking = 1'b1;

        // Frame 8/3 with ready held: valid for exactly one cycle.
        drive(2'b10, ~7'h7F, 1'b0, 1'b0, 3);
        drive(2'b01, ~7'h4F, 1'b1, 1'b0, 3);
        chk("f83 valid before load", int'(valid), 0);
        drive(2'b00, 7'h7F, 1'b1, 1'b0, 1);
        chk("f83 valid", int'(valid), 1);
        chk("f83 Ldigit", int'(Ldigit), 8);
        chk("f83 Rdigit", int'(Rdigit), 3);
        drive(2'b00, 7'h7F, 1'b1, 1'b0, 1);
        chk("f83 valid drop", int'(valid), 0);

        // Two-sample run is rejected; a three-sample run is accepted.
        drive(2'b10, ~7'h06, 1'b0, 1'b0, 2);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 1);
        drive(2'b10, ~7'h06, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 2);
        chk("left only valid", int'(valid), 0);
        drive(2'b01, ~7'h5B, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 2);
        chk("f12 valid", int'(valid), 1);
        chk("f12 Ldigit", int'(Ldigit), 1);
        chk("f12 Rdigit", int'(Rdigit), 2);

        // Second frame 5/6 completes while 1/2 is pending: dropped.
        drive(2'b10, ~7'h6D, 1'b0, 1'b0, 3);
        drive(2'b01, ~7'h7D, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 2);
        chk("ovr overrun", int'(overrun), 1);
        chk("ovr valid", int'(valid), 1);
        chk("ovr Ldigit", int'(Ldigit), 1);
        chk("ovr Rdigit", int'(Rdigit), 2);
        drive(2'b00, 7'h7F, 1'b1, 1'b0, 1);
        chk("ovr release valid", int'(valid), 0);
        chk("ovr sticky", int'(overrun), 1);
        drive(2'b00, 7'h7F, 1'b0, 1'b1, 1);
        chk("ovr clr", int'(overrun), 0);

        // Right digit A is out of range: error, no right load.
        drive(2'b01, ~7'h77, 1'b0, 1'b0, 3);
        chk("errA err", int'(err), 1);
`ifdef SCAN_ERRCNT_EN
        chk("errA errcnt", int'(errcnt), 1);
`endif
        drive(2'b10, ~7'h3F, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 2);
        chk("errA no frame", int'(valid), 0);
        drive(2'b00, 7'h7F, 1'b0, 1'b1, 1);
        chk("errA clr", int'(err), 0);
`ifdef SCAN_ERRCNT_EN
        chk("errA errcnt clr", int'(errcnt), 0);
`endif
        // Invalid pattern with clr on the accepting edge: error wins.
        drive(2'b01, 7'h55, 1'b0, 1'b0, 2);
        drive(2'b01, 7'h55, 1'b0, 1'b1, 1);
        chk("clr vs err", int'(err), 1);
`ifdef SCAN_ERRCNT_EN
        chk("clr vs err errcnt", int'(errcnt), 1);
`endif
        drive(2'b00, 7'h7F, 1'b0, 1'b1, 1);

        // Reset with a left digit pending discards it.
        drive(2'b10, ~7'h66, 1'b0, 1'b0, 3);
        #2 reset = 1'b0;
        Enable = 2'b00;
        @(negedge clkOut);
        check_all_zero("midreset");
        reset = 1'b1;
        drive(2'b01, ~7'h06, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 3);
        chk("right only valid", int'(valid), 0);

        // Present 0/1, then F/7 completes on the same edge ready is high.
        drive(2'b10, ~7'h3F, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b0, 1'b0, 1);
        chk("f01 valid", int'(valid), 1);
        chk("f01 Rdigit", int'(Rdigit), 1);
        drive(2'b10, ~7'h71, 1'b0, 1'b0, 3);
        drive(2'b01, ~7'h07, 1'b0, 1'b0, 3);
        drive(2'b00, 7'h7F, 1'b1, 1'b0, 1);
        chk("fF7 valid", int'(valid), 1);
        chk("fF7 Ldigit", int'(Ldigit), 15);
        chk("fF7 Rdigit", int'(Rdigit), 7);
        chk("fF7 overrun", int'(overrun), 0);
        drive(2'b00, 7'h7F, 1'b1, 1'b0, 1);
        chk("fF7 valid drop", int'(valid), 0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 3, meaning the number of consecutive identical samples needed to accept a digit (range 1..15).
REQ-002 The block SHALL have port clkOut, input, 1 bit: the scan-rate clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port seg, input, 7 bits: multiplexed segment bus, active-low, bit order {g,f,e,d,c,b,a}.
REQ-005 The block SHALL have port Enable, input, 2 bits: digit select; 2'b10 means left digit, 2'b01 means right digit, and any other value means idle.
REQ-006 The block SHALL have port Ldigit, output, 4 bits: decoded left value.
REQ-007 The block SHALL have port Rdigit, output, 3 bits: decoded right value.
REQ-008 The block SHALL have port valid, output, 1 bit: asserted high while Ldigit and Rdigit hold a complete frame.
REQ-009 The block SHALL have port ready, input, 1 bit: consumer accepts the frame.
REQ-010 The block SHALL have port err, output, 1 bit: sticky flag for an invalid pattern or a right value greater than 7.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag for a frame dropped while valid was pending.
REQ-012 The block SHALL have port clr, input, 1 bit: synchronous clear of err, overrun and the error counter.

Function
REQ-013 Decode SHALL use the active-high pattern ~seg against the 16 hex codes 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; any other pattern is invalid.
REQ-014 A stability counter SHALL increment while {Enable,seg} equals the previous sample and non-idle, reset to 1 on change, and saturate at STABLE_CNT.
REQ-015 When the counter first reaches STABLE_CNT, the sample SHALL be accepted exactly once for that run: valid code with left enable → left shadow loaded and Lgot set; valid code 0..7 with right enable → right shadow loaded and Rgot set; otherwise err set and no shadow load.
REQ-016 Idle Enable SHALL reset the stability counter and SHALL NOT clear Lgot or Rgot.
REQ-017 FSM states SHALL be COLLECT and PRESENT.
REQ-018 In COLLECT, when Lgot and Rgot are both set, the block SHALL copy the shadows to Ldigit/Rdigit, clear Lgot/Rgot, assert valid on the next edge, and go to PRESENT.
REQ-019 In PRESENT, valid SHALL stay high and Ldigit/Rdigit SHALL stay stable until a cycle with ready=1, after which valid drops next edge and the FSM returns to COLLECT.
REQ-020 In PRESENT, collection SHALL continue; if Lgot and Rgot both become set before ready, overrun SHALL be set and Lgot/Rgot cleared (frame dropped).
REQ-021 If ready and frame completion coincide in PRESENT, the FSM SHALL load the new frame and remain in PRESENT with valid high.
REQ-022 A re-accepted digit before frame completion SHALL overwrite its shadow (latest wins).
REQ-023 If clr and a new error coincide, the error SHALL win.
REQ-024 Latency from the STABLE_CNT-th sample of the second digit to valid high SHALL be 2 clkOut edges.

Reset
REQ-025 When reset is low, the block SHALL asynchronously enter COLLECT, set Ldigit=0, Rdigit=0, valid=0, err=0, overrun=0, clear counters, shadows and Lgot/Rgot, and set the previous sample to idle; reset mid-frame discards partial data.

Configuration
REQ-026 With SCAN_ERRCNT_EN defined, the block SHALL have an 8-bit output errcnt counting err events, saturating at 255 and cleared by clr or reset; without the macro, neither the port nor the logic SHALL exist and err behaviour is unchanged.

Verification
REQ-027 Enable=10 seg=~7F for 3 cycles, then 01 seg=~4F for 3 cycles, ready=1 → valid high for 1 cycle, Ldigit=8, Rdigit=3.
REQ-028 Left 10/~06 for 2 cycles then changed → no accept; same held 3 cycles → Lgot, and no valid until right digit accepted.
REQ-029 Right pattern ~77 (A) stable 3 cycles → err=1, Rgot unchanged; pulse clr → err=0 (errcnt=1 then 0 with SCAN_ERRCNT_EN).
REQ-030 ready=0 with frame L=1 R=2 presented, then second frame L=5 R=6 completes → overrun=1, outputs remain 1/2, valid held.
REQ-031 reset low asserted after left accepted → all outputs 0; subsequent right-only digit produces no valid.
REQ-032 ready=1 on the same edge a new frame L=F R=7 completes → valid stays high, outputs F/7, overrun=0.
